// File: rtl/input_debouncer.sv
// input_debouncer: cleans up a raw push-button or switch level.
// The raw input passes through a two-flop synchronizer, then a four-state
// FSM with a stability counter. `out` only changes after DEBOUNCE_CYCLES
// consecutive identical synchronized samples, and the one-cycle rise/fall
// strobes are registered alongside it.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in1,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  localparam state_t RESET_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

  logic             sync1_q;
  logic             sync2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  // Two-flop synchronizer: the raw input only ever reaches sync1_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= INIT_LEVEL;
      sync2_q <= INIT_LEVEL;
    end else begin
      sync1_q <= in1;
      sync2_q <= sync1_q;
    end
  end

  // FSM state, counter and every output are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= CNT_ZERO;
      out_q   <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: qualify a new level, drop the candidate on any bounce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      STABLE_LO: begin
        if (sync2_q && SINGLE_SAMPLE) begin
          state_d = STABLE_HI;
          out_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else if (sync2_q) begin
          state_d = CHECK_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      CHECK_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          out_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync2_q && SINGLE_SAMPLE) begin
          state_d = STABLE_LO;
          out_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else if (!sync2_q) begin
          state_d = CHECK_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      CHECK_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          out_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d == CHECK_HI) || (state_d == CHECK_LO);
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed vectors against three debouncer instances
// (N=4 low-idle, N=4 high-idle, N=1 low-idle) sharing one clock and reset.
module tb_input_debouncer;

  logic clk;
  logic rst_n;
  logic inA, inH, inOne;
  logic outA, riseA, fallA, busyA;
  logic outH, riseH, fallH, busyH;
  logic outOne, riseOne, fallOne, busyOne;

  int vecCount  = 0;
  int missCount = 0;

  input_debouncer #(.DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b0)) dutA (
    .clk(clk), .rst_n(rst_n), .in1(inA),
    .out(outA), .rise(riseA), .fall(fallA), .busy(busyA)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b1)) dutH (
    .clk(clk), .rst_n(rst_n), .in1(inH),
    .out(outH), .rise(riseH), .fall(fallH), .busy(busyH)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(1), .INIT_LEVEL(1'b0)) dutOne (
    .clk(clk), .rst_n(rst_n), .in1(inOne),
    .out(outOne), .rise(riseOne), .fall(fallOne), .busy(busyOne)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed bit against its hand-derived value.
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Bounce pattern: value of inA driven before edge e (index e-1).
  logic [11:0] bouncePat;
  logic [11:0] bounceBusy;

  initial begin
    rst_n = 1'b1;
    inA   = 1'b1;
    inH   = 1'b0;
    inOne = 1'b0;

    // Asynchronous reset asserted mid-cycle, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_outA",  outA,  1'b0);
    checkOutput("rst_riseA", riseA, 1'b0);
    checkOutput("rst_fallA", fallA, 1'b0);
    checkOutput("rst_busyA", busyA, 1'b0);
    checkOutput("rst_outH",  outH,  1'b1);
    checkOutput("rst_busyH", busyH, 1'b0);
    checkOutput("rst_outOne", outOne, 1'b0);

    inA = 1'b0; inH = 1'b1; inOne = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("rstHold_outA", outA, 1'b0);
    rst_n = 1'b1;

    // Steady input equal to out: nothing moves.
    repeat (6) applyStimulus();
    checkOutput("idle_outA",  outA,  1'b0);
    checkOutput("idle_busyA", busyA, 1'b0);
    checkOutput("idle_outH",  outH,  1'b1);
    checkOutput("idle_busyH", busyH, 1'b0);
    checkOutput("idle_riseOne", riseOne, 1'b0);

    // Clean press on A and N=1, clean release on H, all before edge 1.
    inA = 1'b1; inH = 1'b0; inOne = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus();
      checkOutput($sformatf("press_outA_e%0d",  e), outA,  e >= 6);
      checkOutput($sformatf("press_riseA_e%0d", e), riseA, e == 6);
      checkOutput($sformatf("press_fallA_e%0d", e), fallA, 1'b0);
      checkOutput($sformatf("press_busyA_e%0d", e), busyA, e >= 3 && e <= 5);
      checkOutput($sformatf("rel_outH_e%0d",  e), outH,  e < 6);
      checkOutput($sformatf("rel_fallH_e%0d", e), fallH, e == 6);
      checkOutput($sformatf("rel_riseH_e%0d", e), riseH, 1'b0);
      checkOutput($sformatf("rel_busyH_e%0d", e), busyH, e >= 3 && e <= 5);
      checkOutput($sformatf("n1_outOne_e%0d",  e), outOne,  e >= 3);
      checkOutput($sformatf("n1_riseOne_e%0d", e), riseOne, e == 3);
      checkOutput($sformatf("n1_busyOne_e%0d", e), busyOne, 1'b0);
    end

    // Clean release on A.
    inA = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus();
      checkOutput($sformatf("relA_outA_e%0d",  e), outA,  e < 6);
      checkOutput($sformatf("relA_fallA_e%0d", e), fallA, e == 6);
      checkOutput($sformatf("relA_riseA_e%0d", e), riseA, 1'b0);
    end

    // Bounce rejection: high 3, low 1, high 3, then low.
    bouncePat  = 12'b0000_0111_0111;
    bounceBusy = 12'b0001_1101_1100;
    for (int e = 1; e <= 12; e++) begin
      inA = bouncePat[e-1];
      applyStimulus();
      checkOutput($sformatf("bounce_outA_e%0d",  e), outA,  1'b0);
      checkOutput($sformatf("bounce_riseA_e%0d", e), riseA, 1'b0);
      checkOutput($sformatf("bounce_busyA_e%0d", e), busyA, bounceBusy[e-1]);
    end

    // Bounce then settle: 1,0,1,0 then hold 1 from edge 5.
    bouncePat = 12'b1111_1111_0101;
    for (int e = 1; e <= 12; e++) begin
      inA = bouncePat[e-1];
      applyStimulus();
      checkOutput($sformatf("settle_outA_e%0d",  e), outA,  e >= 10);
      checkOutput($sformatf("settle_riseA_e%0d", e), riseA, e == 10);
    end

    // Bring A back to low before the mid-qualification reset test.
    inA = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("pre_rst_outA", outA, 1'b0);

    // Reset during qualification: the candidate is discarded.
    inA = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("midq_busyA", busyA, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midq_rst_outA",  outA,  1'b0);
    checkOutput("midq_rst_busyA", busyA, 1'b0);
    repeat (2) applyStimulus();
    checkOutput("midq_hold_outA", outA, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus();
      checkOutput($sformatf("midq_outA_e%0d",  e), outA,  e >= 6);
      checkOutput($sformatf("midq_riseA_e%0d", e), riseA, e == 6);
      checkOutput($sformatf("midq_busyA_e%0d", e), busyA, e >= 3 && e <= 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
